// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, load/store size codes,
// FSM states and the helpers that turn a size code plus byte offset into lane information.
package mem_stage_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } mem_state_e;

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic ls_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        case (funct3[1:0])
            2'b01:   result = offset[0];
            2'b10:   result = (offset != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] ls_byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] ls_store_lanes(input logic [2:0] funct3,
                                                             input logic [WORD_WIDTH-1:0] rs2);
        logic [WORD_WIDTH-1:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{rs2[7:0]}};
            2'b01:   lanes = {2{rs2[15:0]}};
            default: lanes = rs2;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and memory (slave).
interface mem_stage_if;

    logic                                data_req_o;
    logic                                data_gnt_i;
    logic [mem_stage_pkg::WORD_WIDTH-1:0] data_addr_o;
    logic                                data_we_o;
    logic [3:0]                          data_be_o;
    logic [mem_stage_pkg::WORD_WIDTH-1:0] data_wdata_o;
    logic                                data_rvalid_i;
    logic [mem_stage_pkg::WORD_WIDTH-1:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );

endinterface

// File: rtl/mem_stage_load_aligner.sv
// Combinational load extraction: shifts the addressed bytes down to lane 0 and
// sign- or zero-extends them according to the load size code.
module load_aligner
    import mem_stage_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [WORD_WIDTH-1:0] wb_value
);

    logic [WORD_WIDTH-1:0] shifted;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        wb_value = shifted;
        case (funct3)
            LS_B:    wb_value = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    wb_value = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   wb_value = {24'd0, shifted[7:0]};
            LS_HU:   wb_value = {16'd0, shifted[15:0]};
            default: wb_value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory/write-back front end: ALU results pass through, loads/stores run a single
// outstanding req/gnt/rvalid transaction and retire one write-back result each.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  mem_ready_o,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [2:0]            funct3_i,
    input  logic                  rd_we_i,
    mem_stage_if.master           dbus,
    output logic                  wb_valid_o,
    output logic                  wb_we_o,
    output logic [WORD_WIDTH-1:0] wb_data_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_e            state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  req_q;
    logic [WORD_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic                  rd_we_q;
    logic [WORD_WIDTH-1:0] load_value;
    logic                  is_mem;

    assign is_mem             = load_i | store_i;
    assign mem_ready_o        = (state_q == IDLE);
    assign dbus.data_req_o    = req_q;
    assign dbus.data_addr_o   = addr_q;
    assign dbus.data_we_o     = we_q;
    assign dbus.data_be_o     = be_q;
    assign dbus.data_wdata_o  = wdata_q;

    load_aligner u_load_aligner (
        .rdata    (dbus.data_rdata_i),
        .offset   (off_q),
        .funct3   (funct3_q),
        .wb_value (load_value)
    );

    // Retire pulses default low every cycle; each branch below raises the ones it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            rd_we_q      <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_data_o    <= '0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (!is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_we_o    <= rd_we_i;
                            wb_data_o  <= ex_data_i;
                        end else if (ls_misaligned(funct3_i, ex_data_i[1:0])) begin
                            wb_valid_o   <= 1'b1;
                            misaligned_o <= 1'b1;
                            wb_data_o    <= '0;
                        end else begin
                            req_q    <= 1'b1;
                            addr_q   <= {ex_data_i[WORD_WIDTH-1:2], 2'b00};
                            we_q     <= store_i;
                            be_q     <= ls_byte_enable(funct3_i, ex_data_i[1:0]);
                            wdata_q  <= ls_store_lanes(funct3_i, store_data_i);
                            funct3_q <= funct3_i;
                            off_q    <= ex_data_i[1:0];
                            rd_we_q  <= rd_we_i;
                            state_q  <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (dbus.data_gnt_i) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (dbus.data_rvalid_i) begin
                        state_q    <= IDLE;
                        wb_valid_o <= 1'b1;
                        wb_we_o    <= !we_q && rd_we_q;
                        wb_data_o  <= we_q ? '0 : load_value;
                    end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                        state_q    <= IDLE;
                        wb_valid_o <= 1'b1;
                        bus_err_o  <= 1'b1;
                        wb_data_o  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a queue of expected retirements built from the
// load/store rules is checked every cycle, alongside hand-computed literal expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        mem_ready_o;
    logic [31:0] ex_data_i;
    logic [31:0] store_data_i;
    logic        load_i;
    logic        store_i;
    logic [2:0]  funct3_i;
    logic        rd_we_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;
    logic        bus_err_o;

    int   checkCount = 0;
    int   failCount  = 0;
    exp_t expQ[$];

    mem_stage_if dbus ();

    mem_stage #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid_i),
        .mem_ready_o  (mem_ready_o),
        .ex_data_i    (ex_data_i),
        .store_data_i (store_data_i),
        .load_i       (load_i),
        .store_i      (store_i),
        .funct3_i     (funct3_i),
        .rd_we_i      (rd_we_i),
        .dbus         (dbus),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_data_o    (wb_data_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % sizeBytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int n   = sizeBytes(f3);
        int off = int'(addr % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] r = '0;
        int n = sizeBytes(f3);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = rs2[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int     n = sizeBytes(f3);
        longint v = longint'(rdata >> (8 * (addr % 4)));
        if (n < 4) begin
            v = v % (longint'(1) << (8 * n));
            if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        end
        return 32'(v);
    endfunction

    // Compare process: every retire must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_retire", 32'(wb_valid_o), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wb_we", 32'(wb_we_o), 32'(e.we));
                checkOutput("wb_data", wb_data_o, e.data);
                checkOutput("misaligned", 32'(misaligned_o), 32'(e.mis));
                checkOutput("bus_err", 32'(bus_err_o), 32'(e.berr));
            end
        end else begin
            checkOutput("quiet_outputs", {29'd0, wb_we_o, misaligned_o, bus_err_o}, 32'd0);
        end
    end

    task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2, input logic rdWe);
        exp_t e;
        ex_valid_i   = 1'b1;
        load_i       = isLoad;
        store_i      = isStore;
        funct3_i     = f3;
        ex_data_i    = addr;
        store_data_i = rs2;
        rd_we_i      = rdWe;
        if (mem_ready_o) begin
            if (!(isLoad || isStore)) begin
                e = '{we: rdWe, data: addr, mis: 1'b0, berr: 1'b0};
                expQ.push_back(e);
            end else if (modelMisaligned(f3, addr)) begin
                e = '{we: 1'b0, data: 32'd0, mis: 1'b1, berr: 1'b0};
                expQ.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        load_i     = 1'b0;
        store_i    = 1'b0;
    endtask

    // Plays the memory side of one accepted access; junk rvalid during WAIT_GNT must be ignored
    task automatic memTxn(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic isStore, input logic rdWe, input int gntDelay,
                          input logic noResp, input logic [31:0] rdata);
        exp_t e;
        for (int i = 0; i <= gntDelay; i++) begin
            dbus.data_rvalid_i = 1'b1;
            dbus.data_rdata_i  = 32'hDEADBEEF;
            if (i == gntDelay) dbus.data_gnt_i = 1'b1;
            @(negedge clk);
            checkOutput("req_held", 32'(dbus.data_req_o), 32'd1);
            checkOutput("addr_held", dbus.data_addr_o, addr & ~32'h3);
            checkOutput("we_held", 32'(dbus.data_we_o), 32'(isStore));
            checkOutput("be_held", 32'(dbus.data_be_o), 32'(modelBe(f3, addr)));
            if (isStore) checkOutput("wdata_held", dbus.data_wdata_o, modelWdata(f3, rs2));
            checkOutput("ready_busy", 32'(mem_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        dbus.data_gnt_i    = 1'b0;
        dbus.data_rvalid_i = 1'b0;
        checkOutput("req_dropped", 32'(dbus.data_req_o), 32'd0);
        if (noResp) begin
            e = '{we: 1'b0, data: 32'd0, mis: 1'b0, berr: 1'b1};
            expQ.push_back(e);
            repeat (3) begin
                @(posedge clk);
                #1;
                checkOutput("rvalid_wait_busy", 32'(mem_ready_o), 32'd0);
            end
            @(posedge clk);
            #1;
            checkOutput("timeout_bus_err", 32'(bus_err_o), 32'd1);
            checkOutput("timeout_ready", 32'(mem_ready_o), 32'd1);
        end else begin
            e.we   = isStore ? 1'b0 : rdWe;
            e.data = isStore ? 32'd0 : modelLoad(f3, addr, rdata);
            e.mis  = 1'b0;
            e.berr = 1'b0;
            expQ.push_back(e);
            dbus.data_rvalid_i = 1'b1;
            dbus.data_rdata_i  = rdata;
            @(posedge clk);
            #1;
            dbus.data_rvalid_i = 1'b0;
            checkOutput("retire_valid", 32'(wb_valid_o), 32'd1);
            checkOutput("retire_ready", 32'(mem_ready_o), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] aluVals [3];
        aluVals[0] = 32'h11;
        aluVals[1] = 32'h22;
        aluVals[2] = 32'h33;

        rst_n              = 1'b0;
        ex_valid_i         = 1'b0;
        ex_data_i          = '0;
        store_data_i       = '0;
        load_i             = 1'b0;
        store_i            = 1'b0;
        funct3_i           = 3'b000;
        rd_we_i            = 1'b0;
        dbus.data_gnt_i    = 1'b0;
        dbus.data_rvalid_i = 1'b0;
        dbus.data_rdata_i  = '0;

        #3;
        checkOutput("reset_req", 32'(dbus.data_req_o), 32'd0);
        checkOutput("reset_wb", {29'd0, wb_valid_o, wb_we_o, misaligned_o}, 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err_o), 32'd0);
        checkOutput("reset_wb_data", wb_data_o, 32'd0);
        checkOutput("reset_addr", dbus.data_addr_o, 32'd0);
        checkOutput("reset_wdata", dbus.data_wdata_o, 32'd0);
        checkOutput("reset_be_we", {27'd0, dbus.data_be_o, dbus.data_we_o}, 32'd0);
        checkOutput("reset_ready", 32'(mem_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            checkOutput("alu_ready", 32'(mem_ready_o), 32'd1);
            applyStimulus(1'b0, 1'b0, LS_W, aluVals[i], 32'd0, 1'b1);
            checkOutput("alu_wb_valid", 32'(wb_valid_o), 32'd1);
            checkOutput("alu_wb_data", wb_data_o, aluVals[i]);
        end

        applyStimulus(1'b0, 1'b1, LS_B, 32'h103, 32'h123456AB, 1'b1);
        checkOutput("sb_req", 32'(dbus.data_req_o), 32'd1);
        checkOutput("sb_be", 32'(dbus.data_be_o), 32'h8);
        checkOutput("sb_wdata", dbus.data_wdata_o, 32'hABABABAB);
        checkOutput("sb_addr", dbus.data_addr_o, 32'h100);
        memTxn(LS_B, 32'h103, 32'h123456AB, 1'b1, 1'b1, 2, 1'b0, 32'd0);
        checkOutput("sb_wb_we", 32'(wb_we_o), 32'd0);

        applyStimulus(1'b1, 1'b0, LS_H, 32'h202, 32'd0, 1'b1);
        memTxn(LS_H, 32'h202, 32'd0, 1'b0, 1'b1, 0, 1'b0, 32'h80011234);
        checkOutput("lh_data", wb_data_o, 32'hFFFF8001);

        applyStimulus(1'b1, 1'b0, LS_HU, 32'h202, 32'd0, 1'b1);
        memTxn(LS_HU, 32'h202, 32'd0, 1'b0, 1'b1, 1, 1'b0, 32'h80011234);
        checkOutput("lhu_data", wb_data_o, 32'h00008001);

        applyStimulus(1'b1, 1'b0, LS_B, 32'h203, 32'd0, 1'b0);
        memTxn(LS_B, 32'h203, 32'd0, 1'b0, 1'b0, 0, 1'b0, 32'h80112233);
        checkOutput("lb_data", wb_data_o, 32'hFFFFFF80);

        applyStimulus(1'b1, 1'b0, LS_BU, 32'h201, 32'd0, 1'b1);
        memTxn(LS_BU, 32'h201, 32'd0, 1'b0, 1'b1, 0, 1'b0, 32'h80112233);
        checkOutput("lbu_data", wb_data_o, 32'h00000022);

        applyStimulus(1'b0, 1'b1, LS_H, 32'h102, 32'h0000BEEF, 1'b0);
        checkOutput("sh_be", 32'(dbus.data_be_o), 32'hC);
        checkOutput("sh_wdata", dbus.data_wdata_o, 32'hBEEFBEEF);
        memTxn(LS_H, 32'h102, 32'h0000BEEF, 1'b1, 1'b0, 1, 1'b0, 32'd0);

        applyStimulus(1'b0, 1'b1, LS_W, 32'h104, 32'h12345678, 1'b0);
        checkOutput("sw_be", 32'(dbus.data_be_o), 32'hF);
        memTxn(LS_W, 32'h104, 32'h12345678, 1'b1, 1'b0, 0, 1'b0, 32'd0);

        applyStimulus(1'b1, 1'b0, LS_W, 32'h301, 32'd0, 1'b1);
        checkOutput("lw_mis_pulse", 32'(misaligned_o), 32'd1);
        checkOutput("lw_mis_we", 32'(wb_we_o), 32'd0);
        @(negedge clk);
        checkOutput("lw_mis_no_req", 32'(dbus.data_req_o), 32'd0);
        checkOutput("lw_mis_ready", 32'(mem_ready_o), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, LS_H, 32'h101, 32'h5555, 1'b0);
        checkOutput("sh_mis_no_req", 32'(dbus.data_req_o), 32'd0);

        applyStimulus(1'b1, 1'b0, LS_W, 32'h500, 32'd0, 1'b1);
        memTxn(LS_W, 32'h500, 32'd0, 1'b0, 1'b1, 1, 1'b1, 32'd0);

        applyStimulus(1'b1, 1'b0, LS_W, 32'h400, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("pre_reset_req", 32'(dbus.data_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_req_drop", 32'(dbus.data_req_o), 32'd0);
        checkOutput("reset_mid_ready", 32'(mem_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dbus.data_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        dbus.data_gnt_i    = 1'b0;
        dbus.data_rvalid_i = 1'b1;
        dbus.data_rdata_i  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        dbus.data_rvalid_i = 1'b0;
        checkOutput("post_reset_req", 32'(dbus.data_req_o), 32'd0);
        checkOutput("post_reset_no_wb", 32'(wb_valid_o), 32'd0);
        checkOutput("post_reset_ready", 32'(mem_ready_o), 32'd1);

        applyStimulus(1'b0, 1'b0, LS_W, 32'h77, 32'd0, 1'b1);
        checkOutput("recover_wb_data", wb_data_o, 32'h77);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
